// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction queue between fetch and decode.
// Define PC_CAPTURE_EN to carry the fetch PC+4 alongside each entry.
module if_id_queue #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP = '0
) (
  input  logic                         clk,
  input  logic                         R,
  input  logic [WIDTH-1:0]             rom_instruction,
`ifdef PC_CAPTURE_EN
  input  logic [PC_WIDTH-1:0]          pc_plus_4,
`endif
  input  logic                         push,
  input  logic                         LE,
  input  logic                         flush,
  output logic [WIDTH-1:0]             instruction,
`ifdef PC_CAPTURE_EN
  output logic [PC_WIDTH-1:0]          next_pc,
`endif
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PC_WIDTH < 1)
  begin : g_bad_cfg
    $error("if_id_queue: DEPTH must be a power of 2 >= 2");
  end

  typedef struct packed {
`ifdef PC_CAPTURE_EN
    logic [PC_WIDTH-1:0] pc;
`endif
    logic [WIDTH-1:0]    insn;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign wr_entry.insn = rom_instruction;
`ifdef PC_CAPTURE_EN
  assign wr_entry.pc   = pc_plus_4;
`endif

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = LE & valid;
  assign push_ok = push & ~flush & (~full | pop);
  assign drop    = push & ~flush & full & ~pop;

  // Head read is combinational; empty queue shows a bubble.
  always_comb begin
    head        = mem[rd_ptr];
    instruction = valid ? head.insn : NOP;
`ifdef PC_CAPTURE_EN
    next_pc     = valid ? head.pc : '0;
`endif
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and sticky overflow; flush empties in one edge.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= wr_ptr;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed bench with a queue-based reference model.
// Build with PC_CAPTURE_EN defined to also cover the PC+4 path.
module tb_if_id_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0;

  logic        clk;
  logic        R;
  logic [31:0] rom;
  logic [31:0] pc_in;
  logic        push;
  logic        LE;
  logic        flush;
  logic [31:0] instruction;
  logic [31:0] next_pc_o;
  logic        valid;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
  } m_t;

  m_t mq[$];
  bit movf;

  if_id_queue #(
    .WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH), .NOP(NOP)
  ) dut (
    .clk(clk),
    .R(R),
    .rom_instruction(rom),
`ifdef PC_CAPTURE_EN
    .pc_plus_4(pc_in),
    .next_pc(next_pc_o),
`endif
    .push(push),
    .LE(LE),
    .flush(flush),
    .instruction(instruction),
    .valid(valid),
    .full(full),
    .count(count),
    .overflow(overflow)
  );

`ifndef PC_CAPTURE_EN
  assign next_pc_o = 32'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: a FIFO of words with the queue's acceptance rules.
  always @(posedge clk or negedge R) begin
    bit pp;
    bit fu;
    if (!R) begin
      mq.delete();
      movf = 1'b0;
    end else if (flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      pp = LE && (mq.size() > 0);
      fu = (mq.size() == DEPTH);
      if (pp)
        void'(mq.pop_front());
      if (push && (!fu || pp))
        mq.push_back('{rom, pc_in});
      else if (push)
        movf = 1'b1;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("m_valid", 64'(valid), 64'(n != 0));
    chk("m_count", 64'(count), 64'(n));
    chk("m_full", 64'(full), 64'(n == DEPTH));
    chk("m_overflow", 64'(overflow), 64'(movf));
    chk("m_instruction", 64'(instruction),
        64'((n != 0) ? mq[0].insn : NOP));
`ifdef PC_CAPTURE_EN
    chk("m_next_pc", 64'(next_pc_o),
        64'((n != 0) ? mq[0].pc : 32'h0));
`endif
  end

  task automatic cyc(input logic p, input logic le, input logic fl,
                     input logic [31:0] d, input logic [31:0] pc);
    push  = p;
    LE    = le;
    flush = fl;
    rom   = d;
    pc_in = pc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] a [5];
    logic [31:0] b [5];
    R = 1'b1;
    push = 0; LE = 0; flush = 0; rom = 0; pc_in = 0;
    #1 R = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'(0));
    R = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("empty_pop_count", 64'(count), 64'(0));

    // Fill past capacity while decode stalls.
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'hA000_0000 + 32'(i);
      cyc(1, 0, 0, a[i], 32'h0);
      if (i == 3) begin
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_count", 64'(count), 64'(4));
        chk("fill_ovf0", 64'(overflow), 64'(0));
      end
    end
    chk("fill_ovf1", 64'(overflow), 64'(1));
    chk("fill_head", 64'(instruction), 64'(a[0]));
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(instruction), 64'(a[i]));
      cyc(0, 1, 0, 0, 0);
    end
    chk("drain_empty", 64'(valid), 64'(0));
    chk("drain_nop", 64'(instruction), 64'(NOP));
    chk("ovf_sticky", 64'(overflow), 64'(1));

    // Flush with concurrent push and pop.
    cyc(1, 0, 0, 32'hC000_0000, 0);
    cyc(1, 0, 0, 32'hC000_0001, 0);
    chk("pre_flush_count", 64'(count), 64'(2));
    cyc(1, 1, 1, 32'hC000_0002, 0);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(valid), 64'(0));
    chk("flush_nop", 64'(instruction), 64'(NOP));
    chk("flush_ovf", 64'(overflow), 64'(0));
    cyc(1, 0, 0, 32'hC000_0003, 0);
    chk("post_flush_head", 64'(instruction), 64'hC000_0003);
    cyc(0, 1, 0, 0, 0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      b[i] = 32'hB000_0000 + 32'(i);
      cyc(1, 0, 0, b[i], 0);
    end
    b[4] = 32'hB000_00BB;
    cyc(1, 1, 0, b[4], 0);
    chk("pp_count", 64'(count), 64'(4));
    chk("pp_ovf", 64'(overflow), 64'(0));
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", 64'(instruction), 64'(b[i]));
      cyc(0, 1, 0, 0, 0);
    end
    chk("pp_empty", 64'(valid), 64'(0));

    // Streaming: one in, one out, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 32'h5700_0000 + 32'(i), 0);
      chk("stream_word", 64'(instruction), 64'h5700_0000 + 64'(i));
      chk("stream_count", 64'(count), 64'(1));
    end
    cyc(0, 1, 0, 0, 0);
    chk("stream_end", 64'(valid), 64'(0));

    // Asynchronous reset mid-stream at count 3.
    cyc(1, 0, 0, 32'hD000_0000, 0);
    cyc(1, 0, 0, 32'hD000_0001, 0);
    cyc(1, 0, 0, 32'hD000_0002, 0);
    chk("mid_count3", 64'(count), 64'(3));
    push = 0;
    #1 R = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_instr", 64'(instruction), 64'h0);
    chk("arst_ovf", 64'(overflow), 64'(0));
    cyc(0, 0, 0, 0, 0);
    R = 1'b1;
    cyc(1, 0, 0, 32'hE3A0_1005, 0);
    chk("arst_push_valid", 64'(valid), 64'(1));
    chk("arst_push_instr", 64'(instruction), 64'hE3A0_1005);
    cyc(0, 1, 0, 0, 0);

`ifdef PC_CAPTURE_EN
    cyc(1, 0, 0, 32'h11, 32'h104);
    cyc(1, 0, 0, 32'h22, 32'h108);
    chk("pc_head", 64'(next_pc_o), 64'h104);
    cyc(0, 1, 0, 0, 0);
    chk("pc_second", 64'(next_pc_o), 64'h108);
    chk("pc_second_instr", 64'(instruction), 64'h22);
    cyc(0, 1, 0, 0, 0);
    chk("pc_empty", 64'(next_pc_o), 64'h0);
`endif

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Instruction queue of DEPTH entries between fetch (ROM) and decode.
- Supports decode stall via LE, branch flush, valid tagging with NOP bubbles, and sticky overflow detection.
- Optionally carries the fetch PC+4 alongside each instruction.

Parameters:
- WIDTH, 32, instruction width in bits.
- PC_WIDTH, 32, width of the PC+4 field; used only when PC_CAPTURE_EN is defined.
- DEPTH, 4, number of entries. Must be a power of 2 and >= 2.
- NOP, 32'h00000000, value driven on instruction whenever valid=0. Must be WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  asynchronous, active-low reset.
- rom_instruction  input  WIDTH  instruction word from fetch.
- pc_plus_4  input  PC_WIDTH  fetch PC+4. Present only with PC_CAPTURE_EN.
- push  input  1  fetch presents rom_instruction this cycle.
- LE  input  1  decode consumes the head entry this cycle (pop).
- flush  input  1  synchronous discard of all entries (taken branch).
- instruction  output  WIDTH  head entry, or NOP when valid=0.
- next_pc  output  PC_WIDTH  head entry's PC+4, or 0 when valid=0. Present only with PC_CAPTURE_EN.
- valid  output  1  queue non-empty; instruction is real.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (R=0, asynchronous, any time):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: valid=0, full=0, instruction=NOP, next_pc=0.
  - Storage array contents need not be cleared.
  - A reset asserted mid-operation discards all entries immediately, with no clock edge required.
- Storage and pointers:
  - Circular buffer of registers.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Outputs:
  - instruction and next_pc are a combinational read of storage[rd_ptr], gated by valid.
  - valid = (count != 0); full = (count == DEPTH).
- Pop: pop = LE & valid. LE while empty is a no-op; no pointer moves and no underflow occurs.
- Push acceptance: push_ok = push & ~flush & (~full | pop).
  - A push is accepted while full if a pop occurs in the same cycle.
- Latency: a word pushed into an empty queue appears on instruction with valid=1 on the cycle after the push edge. There is no same-cycle bypass.
- Each clock edge with no flush:
  - If push_ok: write storage[wr_ptr], then increment wr_ptr.
  - If pop: increment rd_ptr.
  - count changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- Flush (synchronous, highest priority below reset):
  - On the edge: count=0 and rd_ptr=wr_ptr (pointer equality; no need to zero them).
  - Any same-cycle push and pop are ignored.
  - Next cycle: valid=0 and instruction=NOP.
  - overflow is cleared.
- Overflow:
  - Set when push & ~flush & full & ~pop; the word is dropped.
  - Remains set until reset or flush.
- Stall: LE=0 holds the head entry and all outputs stable. Pushes continue until full.

Optional Feature:
- Macro: PC_CAPTURE_EN.
- Defined:
  - The pc_plus_4 input and next_pc output exist.
  - Each accepted push stores {pc_plus_4, rom_instruction} as one entry.
  - next_pc tracks the head entry exactly as instruction does.
  - next_pc=0 when valid=0, including after reset and after flush.
- Undefined:
  - The ports and the PC storage are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset with R=0 mid-stream while count=3 -> same cycle: valid=0, count=0, instruction=32'h0, overflow=0. After R=1, a push of 32'hE3A01005 -> next cycle valid=1, instruction=32'hE3A01005.
2. LE=0; push 5 words A0..A4 with DEPTH=4 -> full=1 after the 4th push, count=4, overflow=1 after the 5th. Pops then return A0..A3 in order, and A4 never appears.
3. Full queue; push=1 and LE=1 in the same cycle with word B -> count stays 4, overflow stays 0. Four further pops yield the old entries 2..4, then B.
4. Push/pop streaming of 10 words with LE=1 every cycle -> pointers wrap past DEPTH-1. Output order is W0..W9, each valid for one cycle, and count stays <=1.
5. count=2; flush=1 together with push=1 and LE=1 -> next cycle count=0, valid=0, instruction=NOP. The pushed word is dropped, and overflow is cleared if previously set.
6. With PC_CAPTURE_EN: push (32'h11, 32'h104) then (32'h22, 32'h108) -> head next_pc=32'h104; after one pop, next_pc=32'h108. When empty, next_pc=0.
